// File: rtl/sprite_rom_arbiter_pkg.sv
// sprite_rom_pkg: shared sizes and types for the sprite ROM arbiter
package sprite_rom_pkg;
  localparam int N_REQ = 4;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 4;
  localparam int ROM_LAT = 1;
  typedef logic [N_REQ-1:0] req_onehot_t;
  typedef logic [ADDR_W-1:0] rom_addr_t;
  typedef logic [DATA_W-1:0] rom_data_t;
endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// sprite_rom_arbiter_if: requester-side request, grant and tagged-response bundle
interface sprite_rom_arbiter_if #(
  parameter int N_REQ = sprite_rom_pkg::N_REQ,
  parameter int ADDR_W = sprite_rom_pkg::ADDR_W,
  parameter int DATA_W = sprite_rom_pkg::DATA_W
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ-1:0] rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [2:0] inflight;
  modport master(output req_valid, req_addr, input req_ready, rsp_valid, rsp_data, inflight);
  modport slave(input req_valid, req_addr, output req_ready, rsp_valid, rsp_data, inflight);
endinterface

// File: rtl/sprite_rom_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant over a request vector; the pointer moves past each enabled grant
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         vga_clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr, ptr_nxt;
  logic [N-1:0] raw;
  // Scan a doubled index range starting at ptr so the lowest k wins, which wraps the search.
  always_comb begin
    raw = '0;
    ptr_nxt = ptr;
    for (int k = 2*N-1; k >= 0; k--)
      if (k >= int'(ptr) && req[k % N]) begin
        raw = N'(1) << (k % N);
        ptr_nxt = PW'((k + 1) % N);
      end
  end
  assign gnt = en ? raw : '0;
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) ptr <= '0;
    else if (en && |req) ptr <= ptr_nxt;
endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: one sprite ROM shared by N_REQ requesters; requester 0 has strict
// priority, 1..N_REQ-1 round-robin; tagged responses return ROM_LAT+1 cycles after accept.
module sprite_rom_arbiter #(
  parameter int N_REQ = sprite_rom_pkg::N_REQ,
  parameter int ADDR_W = sprite_rom_pkg::ADDR_W,
  parameter int DATA_W = sprite_rom_pkg::DATA_W,
  parameter int ROM_LAT = sprite_rom_pkg::ROM_LAT
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  sprite_rom_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q
);
  logic [N_REQ-1:0] grant;
  logic [N_REQ-2:0] rr_gnt;
  logic [ADDR_W-1:0] gnt_addr;
  logic [N_REQ-1:0] tag [ROM_LAT+1];
  rr_arbiter #(.N(N_REQ-1)) u_rr (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .en(!bus.req_valid[0]),
    .req(bus.req_valid[N_REQ-1:1]),
    .gnt(rr_gnt)
  );
  assign grant = bus.req_valid[0] ? N_REQ'(1) : {rr_gnt, 1'b0};
  assign bus.req_ready = grant;
  assign bus.rsp_valid = tag[ROM_LAT];
  always_comb begin
    gnt_addr = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) gnt_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
  end
  // rom_q for the read tagged in stage ROM_LAT-1 is valid at this edge.
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) begin
      rom_address <= '0;
      bus.rsp_data <= '0;
      bus.inflight <= '0;
      for (int i = 0; i <= ROM_LAT; i++) tag[i] <= '0;
    end else begin
      if (|grant) rom_address <= gnt_addr;
      tag[0] <= grant;
      for (int i = 1; i <= ROM_LAT; i++) tag[i] <= tag[i-1];
      if (|tag[ROM_LAT-1]) bus.rsp_data <= rom_q;
      bus.inflight <= bus.inflight + 3'(|grant) - 3'(|tag[ROM_LAT]);
    end
endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
Shares one synchronous, palette-indexed sprite ROM between several draw requesters: the per-pixel background path and the sprite layers (player, enemies, blocks). Requester 0 has strict priority so the pixel path never misses a slot. Requesters 1..N_REQ-1 share the remaining slots round-robin. Returns are tagged and arrive at a fixed latency; the palette lookup sits downstream on rsp_data.

Parameters:
N_REQ, 4, number of requesters (2..8); index 0 is strict-priority
ADDR_W, 14, ROM address width
DATA_W, 4, ROM word (palette index) width
ROM_LAT, 1, cycles from rom_address change to rom_q valid at the next posedge (1 = negedge-clocked ROM)

Ports:
vga_clk  in  1  pixel clock; all state on posedge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  N_REQ  per-requester read request
req_addr  in  N_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
req_ready  out  N_REQ  one-hot grant; combinational from req_valid and the round-robin pointer
rom_address  out  ADDR_W  registered address to the ROM
rom_q  in  DATA_W  ROM read data
rsp_valid  out  N_REQ  one-hot, one-cycle return strobe
rsp_data  out  DATA_W  registered ROM word for the strobed requester
inflight  out  3  count of accepted reads whose rsp_valid has not yet pulsed

Behaviour:
- Reset (async assert, sync release): rom_address=0, rsp_valid=0, rsp_data=0, inflight=0, RR pointer=1, tag pipeline cleared. Reads in flight at reset are discarded and never returned.
- Arbitration, per cycle, at most one grant:
  - If req_valid[0], grant 0.
  - Otherwise grant the first i with req_valid[i] set, searching from the RR pointer upward through 1..N_REQ-1 and wrapping back to 1.
  - req_ready is all-zero when no request is valid.
- Accept: a transfer occurs when req_valid[i] && req_ready[i]. No ready-before-valid dependency. A requester holds valid and address until it is accepted.
- RR pointer: updates only on a grant to i≥1, becoming i+1 (wrapping N_REQ-1 → 1). Grants to requester 0 leave it unchanged.
- rom_address: loaded with the granted address at the accept edge. Holds its previous value when nothing is granted.
- Tag pipeline: a one-hot tag shift register of depth ROM_LAT+1, inserted at accept.
- Response timing: for an accept in cycle t, rsp_data <= rom_q at the end of cycle t+ROM_LAT. rsp_valid equals that tag during cycle t+ROM_LAT+1. Total latency is ROM_LAT+1 cycles (2 at default).
- Ordering and backpressure: responses come back in accept order, one per cycle, with no backpressure. Requesters must be able to sink them.
- rsp_data holds its last value when rsp_valid is zero.
- Back-to-back: a new grant is allowed every cycle, giving a sustained throughput of 1 read per cycle.
- inflight:
  - +1 on accept, -1 on rsp_valid.
  - Both in the same cycle: unchanged.
  - Maximum is ROM_LAT+1.
- Simultaneous events: when requester 0 and others are all valid, 0 wins every cycle. Requesters 1..N_REQ-1 starve while req_valid[0] is held; this is documented, not an error.
- An X or unknown on req_addr of a non-granted requester has no effect.

Decomposition:
- Package sprite_rom_pkg: N_REQ, ADDR_W, DATA_W, ROM_LAT localparams; typedef req_onehot_t = logic [N_REQ-1:0]; typedef rom_addr_t, rom_data_t.
- Sub-module rr_arbiter: round-robin over a request vector with pointer state and a grant-enable input. It is instantiated for requesters 1..N_REQ-1. Priority override, address mux and tag pipeline stay in the top level.

Test Plan:
- Reset with no requests: outputs 0. Pulse req_valid[2] addr 0x0123 for one accept → rom_address=0x0123 next cycle; rsp_valid=4'b0100 exactly 2 cycles after accept, with rsp_data = the ROM model word at 0x0123.
- Requesters 1, 2, 3 valid continuously from reset → grants cycle 1,2,3,1,2,3… Responses follow the same order with 2-cycle lag. inflight stays 2.
- Requester 0 and 1..3 all valid → req_ready=0001 every cycle. Drop req_valid[0] → next grant goes to 1, then 2 (pointer unchanged by the req0 grants).
- Pointer at 3, only req_valid[1] set → grant 1. Pointer becomes 2; verify with a following 1/2/3 burst starting at 2.
- Accept in cycle t, deassert reset_n during t+1 → no rsp_valid ever pulses. inflight=0 and rom_address=0 immediately on assertion.
- Alternate idle and request cycles with ROM_LAT=2 build → latency 3. rom_address holds during idle cycles. Same-cycle accept and return leave inflight unchanged.
